// File: rtl/cam_pkg.sv
// Shared types and constants for the camera capture controller.
// Holds the capture FSM state type, QQVGA frame geometry and the default
// frame-buffer address width.
package cam_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_SYNC    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } cam_state_t;

  localparam int QQVGA_W    = 160;
  localparam int QQVGA_H    = 120;
  localparam int QQVGA_NPIX = 19200;
  localparam int CAM_AW     = 15;

endpackage

// File: rtl/cam_edge_det.sv
// Rise/fall detection for the camera VSYNC and HREF strobes.
// The previous sample of each strobe is held in a register; the edge
// outputs compare the live input against that registered sample.
module cam_edge_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_vsync,
  input  logic i_href,
  output logic o_vsync_rise,
  output logic o_vsync_fall,
  output logic o_href_rise,
  output logic o_href_fall
);

  logic r_vsync;
  logic r_href;

  // Remember last-cycle level of both strobes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vsync <= 1'b0;
      r_href  <= 1'b0;
    end else begin
      r_vsync <= i_vsync;
      r_href  <= i_href;
    end
  end

  assign o_vsync_rise = i_vsync & ~r_vsync;
  assign o_vsync_fall = ~i_vsync & r_vsync;
  assign o_href_rise  = i_href & ~r_href;
  assign o_href_fall  = ~i_href & r_href;

endmodule

// File: rtl/cam_capture_ctrl.sv
// Camera frame-capture controller: arms on a start request, waits for a
// full vertical blank so only whole frames are captured, enables the pixel
// writer for one frame and reports completion.
// Optional frame checking (line count, pixel count, overrun) is built only
// when the macro CAPTURE_CHECK_EN is defined; otherwise frame_err is 0.
module cam_capture_ctrl
  import cam_pkg::*;
#(
  parameter int AW      = CAM_AW,
  parameter int NPIXELS = QQVGA_NPIX,
  parameter int NLINES  = QQVGA_H
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic          VSYNC,
  input  logic          HREF,
  input  logic          px_wr,
  input  logic          start,
  input  logic          continuous,
  output logic          cap_en,
  output logic          addr_clr,
  output logic          busy,
  output logic          frame_done,
  output logic          frame_err,
  output logic [AW-1:0] px_cnt
);

  localparam int            LW         = $clog2(NLINES + 1);
  localparam logic [AW-1:0] LP_NPIX    = AW'(NPIXELS);
  localparam logic [LW-1:0] LP_NLINES  = LW'(NLINES);

  cam_state_t    r_state;
  cam_state_t    w_next;
  logic          r_cap_en;
  logic          r_addr_clr;
  logic          r_busy;
  logic          r_frame_done;
  logic [AW-1:0] r_px_cnt;
  logic          w_at_full;
  logic          w_vs_rise;
  logic          w_vs_fall;
  logic          w_href_rise;
  logic          w_href_fall;
  logic          w_unused;

  cam_edge_det u_edge (
    .i_clk        (CLK),
    .i_rst        (rst),
    .i_vsync      (VSYNC),
    .i_href       (HREF),
    .o_vsync_rise (w_vs_rise),
    .o_vsync_fall (w_vs_fall),
    .o_href_rise  (w_href_rise),
    .o_href_fall  (w_href_fall)
  );

  assign w_at_full = (r_px_cnt == LP_NPIX);

  // State register plus registered outputs decoded from the next state,
  // so every output lines up with the state it belongs to.
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cap_en     <= 1'b0;
      r_addr_clr   <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_cap_en     <= (w_next == ST_CAPTURE);
      r_addr_clr   <= (w_next == ST_SYNC);
      r_busy       <= (w_next != ST_IDLE);
      r_frame_done <= (w_next == ST_DONE);
    end
  end

  // Next-state logic. CAPTURE is only entered after VSYNC has been seen
  // high in ARM, so a VSYNC rise inside CAPTURE is the end of the frame.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (start) w_next = ST_ARM;
      ST_ARM:     if (VSYNC) w_next = ST_SYNC;
      ST_SYNC:    if (!VSYNC) w_next = ST_CAPTURE;
      ST_CAPTURE: if (w_vs_rise || w_at_full) w_next = ST_DONE;
      ST_DONE:    w_next = continuous ? ST_ARM : ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Pixel counter: cleared in SYNC, counts writes in CAPTURE, saturates at
  // a full frame and otherwise holds its final value for software to read.
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_px_cnt <= '0;
    end else if (r_state == ST_SYNC) begin
      r_px_cnt <= '0;
    end else if (r_state == ST_CAPTURE && px_wr && !w_at_full) begin
      r_px_cnt <= r_px_cnt + 1'b1;
    end
  end

`ifdef CAPTURE_CHECK_EN
  logic [LW-1:0] r_line_cnt;
  logic          r_overrun;
  logic          r_frame_err;

  // Line counter and overrun flag for the frame currently being captured.
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_line_cnt <= '0;
      r_overrun  <= 1'b0;
    end else if (r_state == ST_SYNC) begin
      r_line_cnt <= '0;
      r_overrun  <= 1'b0;
    end else if (r_state == ST_CAPTURE) begin
      if (w_href_fall && (r_line_cnt != '1)) r_line_cnt <= r_line_cnt + 1'b1;
      if (px_wr && w_at_full)                r_overrun  <= 1'b1;
    end
  end

  // Frame verdict taken in DONE and held until the next frame completes.
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_frame_err <= 1'b0;
    end else if (r_state == ST_DONE) begin
      r_frame_err <= (r_px_cnt != LP_NPIX) || (r_line_cnt != LP_NLINES) || r_overrun;
    end
  end

  assign frame_err = r_frame_err;
  assign w_unused  = ^{w_vs_fall, w_href_rise};
`else
  assign frame_err = 1'b0;
  assign w_unused  = ^{w_vs_fall, w_href_rise, w_href_fall, LP_NLINES};
`endif

  assign cap_en     = r_cap_en;
  assign addr_clr   = r_addr_clr;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign px_cnt     = r_px_cnt;

endmodule
